// File: rtl/ltc_frame_aligner.sv
// ltc_frame_aligner
// Word-aligns the LTC2175 deserialized frame lane by issuing bitslip pulses
// until FR reads FRAME_PATTERN, then tracks loss of lock and interleaves the
// two data lanes of one channel into 16-bit samples.
// Optional build macro: LTC_TEST_PATTERN_EN adds a test-pattern error counter
// (ports i_pattern_clr / o_pattern_err and parameter TEST_PATTERN).
module ltc_frame_aligner #(
`ifdef LTC_TEST_PATTERN_EN
  parameter logic [15:0] TEST_PATTERN  = 16'h000D,
`endif
  parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
  parameter int unsigned MATCH_CNT     = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned MAX_SLIPS     = 16,
  parameter int unsigned LOSS_CNT      = 3
) (
  input  logic        i_sample_clk,
  input  logic        i_sample_rst,
  input  logic        i_align_en,
  input  logic [7:0]  i_frame_data,
  input  logic [7:0]  i_lane_a,
  input  logic [7:0]  i_lane_b,
`ifdef LTC_TEST_PATTERN_EN
  input  logic        i_pattern_clr,
  output logic [15:0] o_pattern_err,
`endif
  output logic        o_bitslip,
  output logic        o_locked,
  output logic        o_fail,
  output logic [7:0]  o_slip_count,
  output logic [15:0] o_err_count,
  output logic [15:0] o_sample,
  output logic        o_sample_valid
);

  localparam logic [3:0] MATCH_LIM  = 4'(MATCH_CNT);
  localparam logic [3:0] LOSS_LIM   = 4'(LOSS_CNT);
  localparam logic [7:0] SETTLE_END = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SLIP_LIM   = 8'(MAX_SLIPS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_frame_ok;
  logic [3:0]  r_match_cnt;
  logic [3:0]  r_loss_cnt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  r_slip_cnt;
  logic [15:0] r_err_cnt;
  logic        r_bitslip;
  logic        r_locked;
  logic        r_fail;
  logic [15:0] r_sample;
  logic        r_sample_valid;
  logic [15:0] w_sample_asm;

  assign w_frame_ok = (i_frame_data == FRAME_PATTERN);

  // State register; status outputs registered from the next state so they track it exactly
  always_ff @(posedge i_sample_clk) begin
    if (i_sample_rst) begin
      r_state   <= ST_IDLE;
      r_bitslip <= 1'b0;
      r_locked  <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_bitslip <= (w_next_state == ST_SLIP);
      r_locked  <= (w_next_state == ST_LOCKED);
      r_fail    <= (w_next_state == ST_FAIL);
    end
  end

  // Next-state logic; dropping align_en overrides every other transition
  always_comb begin
    w_next_state = r_state;
    if (!i_align_en) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_next_state = ST_CHECK;
        end
        ST_CHECK: begin
          if (w_frame_ok) begin
            if ((r_match_cnt + 4'd1) == MATCH_LIM) begin
              w_next_state = ST_LOCKED;
            end else begin
              w_next_state = ST_CHECK;
            end
          end else if (r_slip_cnt < SLIP_LIM) begin
            w_next_state = ST_SLIP;
          end else begin
            w_next_state = ST_FAIL;
          end
        end
        ST_SLIP: begin
          w_next_state = ST_WAIT;
        end
        ST_WAIT: begin
          if (r_wait_cnt == SETTLE_END) begin
            w_next_state = ST_CHECK;
          end else begin
            w_next_state = ST_WAIT;
          end
        end
        ST_LOCKED: begin
          if (!w_frame_ok && ((r_loss_cnt + 4'd1) == LOSS_LIM)) begin
            w_next_state = ST_CHECK;
          end else begin
            w_next_state = ST_LOCKED;
          end
        end
        ST_FAIL: begin
          w_next_state = ST_FAIL;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Alignment counters: match run, settle wait and loss run restart whenever their state is left
  always_ff @(posedge i_sample_clk) begin
    if (i_sample_rst) begin
      r_match_cnt <= 4'd0;
      r_wait_cnt  <= 8'd0;
      r_loss_cnt  <= 4'd0;
    end else begin
      if ((r_state == ST_CHECK) && (w_next_state == ST_CHECK) && w_frame_ok) begin
        r_match_cnt <= r_match_cnt + 4'd1;
      end else begin
        r_match_cnt <= 4'd0;
      end
      if ((r_state == ST_WAIT) && (w_next_state == ST_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= 8'd0;
      end
      if ((r_state == ST_LOCKED) && (w_next_state == ST_LOCKED) && !w_frame_ok) begin
        r_loss_cnt <= r_loss_cnt + 4'd1;
      end else begin
        r_loss_cnt <= 4'd0;
      end
    end
  end

  // Slip count per attempt: cleared in IDLE and on loss of lock, saturates at 255
  always_ff @(posedge i_sample_clk) begin
    if (i_sample_rst) begin
      r_slip_cnt <= 8'd0;
    end else if ((w_next_state == ST_IDLE) ||
                 ((r_state == ST_LOCKED) && (w_next_state == ST_CHECK))) begin
      r_slip_cnt <= 8'd0;
    end else if ((w_next_state == ST_SLIP) && (r_slip_cnt != 8'hFF)) begin
      r_slip_cnt <= r_slip_cnt + 8'd1;
    end else begin
      r_slip_cnt <= r_slip_cnt;
    end
  end

  // Saturating FR mismatch count while locked; only reset clears it
  always_ff @(posedge i_sample_clk) begin
    if (i_sample_rst) begin
      r_err_cnt <= 16'd0;
    end else if ((r_state == ST_LOCKED) && !w_frame_ok && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  // Interleave lanes: lane_a supplies odd sample bits, lane_b the even ones
  always_comb begin
    w_sample_asm = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      w_sample_asm[15 - 2*k] = i_lane_a[7 - k];
      w_sample_asm[14 - 2*k] = i_lane_b[7 - k];
    end
  end

  // Sample register updates every cycle; valid marks cycles captured while locked
  always_ff @(posedge i_sample_clk) begin
    if (i_sample_rst) begin
      r_sample       <= 16'h0000;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample       <= w_sample_asm;
      r_sample_valid <= (r_state == ST_LOCKED);
    end
  end

`ifdef LTC_TEST_PATTERN_EN
  logic [15:0] r_pattern_err;

  // Saturating count of valid samples that differ from the test pattern; clear wins
  always_ff @(posedge i_sample_clk) begin
    if (i_sample_rst) begin
      r_pattern_err <= 16'd0;
    end else if (i_pattern_clr) begin
      r_pattern_err <= 16'd0;
    end else if (r_sample_valid && (r_sample != TEST_PATTERN) && (r_pattern_err != 16'hFFFF)) begin
      r_pattern_err <= r_pattern_err + 16'd1;
    end else begin
      r_pattern_err <= r_pattern_err;
    end
  end

  assign o_pattern_err = r_pattern_err;
`endif

  assign o_bitslip      = r_bitslip;
  assign o_locked       = r_locked;
  assign o_fail         = r_fail;
  assign o_slip_count   = r_slip_cnt;
  assign o_err_count    = r_err_cnt;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_sample_valid;

endmodule
